adder_share_arb: RTL and testbench

//  Shares one registered adder datapath (a+b, carry out) among NREQ requesters.
//  - Round-robin arbitration, per-requester valid/ready handshake.
//  - 2-stage pipeline: operand register, then sum register.
//  - Sits between the request-side masters and the single adder instance; each result is returned tagged with the requester ID.

---
 rtl/adder_share_arb.sv | 146 ++++++++++++++
 tb/tb_adder_share_arb.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arb.sv
// Round-robin share of one registered adder (operand reg -> sum reg) among NREQ requesters.
// Optional ADDSHARE_LOCK_EN adds req_lock: a requester can hold the grant across several beats.
module adder_share_arb #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 16,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
`ifdef ADDSHARE_LOCK_EN
   input  logic [NREQ-1:0]       req_lock,
`endif
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH:0]        rsp_sum
);

   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   win;
   logic [IDW-1:0]   nxt_ptr;
   logic [IDW:0]     idx;
   logic             found;
   logic             s1_vld;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [IDW-1:0]   s1_id;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             s2_adv;
   logic             s1_adv;
   logic             xfer;

`ifdef ADDSHARE_LOCK_EN
   logic             lock_active;
   logic [IDW-1:0]   lock_id;
`endif

   assign s2_adv = !rsp_valid || rsp_ready;
   assign s1_adv = !s1_vld || s2_adv;

   // Scan from ptr upward with wrap; first valid requester wins.
   always_comb begin
      win   = '0;
      found = 1'b0;
      idx   = '0;
`ifdef ADDSHARE_LOCK_EN
      if (lock_active) begin
         win   = lock_id;
         found = req_valid[lock_id];
      end else begin
`endif
         for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NREQ)) begin
               idx = idx - (IDW+1)'(NREQ);
            end
            if (!found && req_valid[idx[IDW-1:0]]) begin
               found = 1'b1;
               win   = idx[IDW-1:0];
            end
         end
`ifdef ADDSHARE_LOCK_EN
      end
`endif
   end

   always_comb begin
      req_ready = '0;
      if (found && s1_adv) begin
         req_ready[win] = 1'b1;
      end
   end

   assign xfer    = found && s1_adv;
   assign nxt_ptr = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;

   always_comb begin
      op_a = '0;
      op_b = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (win == IDW'(k)) begin
            op_a = req_a[k*WIDTH +: WIDTH];
            op_b = req_b[k*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr <= '0;
`ifdef ADDSHARE_LOCK_EN
         lock_active <= 1'b0;
         lock_id     <= '0;
`endif
      end else if (xfer) begin
`ifdef ADDSHARE_LOCK_EN
         // A locked transfer freezes ptr; the unlocking beat moves it past the holder.
         if (req_lock[win]) begin
            lock_active <= 1'b1;
            lock_id     <= win;
         end else begin
            lock_active <= 1'b0;
            ptr         <= nxt_ptr;
         end
`else
         ptr <= nxt_ptr;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_vld <= 1'b0;
         s1_a   <= '0;
         s1_b   <= '0;
         s1_id  <= '0;
      end else if (s1_adv) begin
         s1_vld <= xfer;
         if (xfer) begin
            s1_a  <= op_a;
            s1_b  <= op_b;
            s1_id <= win;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_sum   <= '0;
      end else if (s2_adv) begin
         rsp_valid <= s1_vld;
         if (s1_vld) begin
            rsp_sum <= {1'b0, s1_a} + {1'b0, s1_b};
            rsp_id  <= s1_id;
         end
      end
   end

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed bench for adder_share_arb: reset, sums/carry, round-robin order, stalls, mid-stream reset.
module tb_adder_share_arb;

   logic        clk;
   logic        reset_n;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [63:0] req_a;
   logic [63:0] req_b;
`ifdef ADDSHARE_LOCK_EN
   logic [3:0]  req_lock;
`endif
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_id;
   logic [16:0] rsp_sum;

   int errors = 0;
   int checks = 0;

   logic [16:0] rr_sum [4] = '{17'h00010, 17'h00111, 17'h00212, 17'h00313};

   adder_share_arb #(.NREQ(4), .WIDTH(16)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
`ifdef ADDSHARE_LOCK_EN
      .req_lock  (req_lock),
`endif
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset_n   = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b1;
`ifdef ADDSHARE_LOCK_EN
      req_lock  = '0;
`endif
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic load_rr_operands;
      for (int i = 0; i < 4; i++) begin
         req_a[i*16 +: 16] = 16'h0010 + 16'(i);
         req_b[i*16 +: 16] = 16'(i * 256);
      end
   endtask

   task automatic test_reset;
      reset_n   = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b0;
      req_a     = '0;
      req_b     = '0;
`ifdef ADDSHARE_LOCK_EN
      req_lock  = '0;
`endif
      #1 reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", rsp_valid); end
      checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_id got=%0d want=0", rsp_id); end
      checks++; if (rsp_sum !== 17'h0) begin errors++; $display("FAIL reset_sum got=%h want=0", rsp_sum); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
      reset_n = 1'b1;
   endtask

   task automatic test_basic;
      tick;
      req_a[15:0] = 16'h0003;
      req_b[15:0] = 16'h0004;
      req_valid   = 4'b0001;
      rsp_ready   = 1'b1;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL basic_ready got=%b want=0001", req_ready); end
      tick;
      req_valid = '0;
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b want=0", rsp_valid); end
      tick;
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b want=1", rsp_valid); end
      checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL basic_id got=%0d want=0", rsp_id); end
      checks++; if (rsp_sum !== 17'h00007) begin errors++; $display("FAIL basic_sum got=%h want=00007", rsp_sum); end
      tick;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got=%b want=0", rsp_valid); end
   endtask

   task automatic test_carry;
      tick;
      req_a[47:32] = 16'hFFFF;
      req_b[47:32] = 16'hFFFF;
      req_valid    = 4'b0100;
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL carry_ready got=%b want=0100", req_ready); end
      tick;
      req_valid = '0;
      tick;
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL carry_valid got=%b want=1", rsp_valid); end
      checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL carry_id got=%0d want=2", rsp_id); end
      checks++; if (rsp_sum !== 17'h1FFFE) begin errors++; $display("FAIL carry_sum got=%h want=1fffe", rsp_sum); end
   endtask

   task automatic test_round_robin;
      logic [1:0] exp_id;
      do_reset;
      load_rr_operands;
      req_valid = 4'b1111;
      for (int k = 0; k < 10; k++) begin
         if (k == 8) req_valid = '0;
         #1;
         if (k < 8) begin
            checks++; if (req_ready !== (4'b0001 << (k % 4))) begin errors++; $display("FAIL rr_grant k=%0d got=%b want=%b", k, req_ready, 4'b0001 << (k % 4)); end
         end
         if (k >= 2) begin
            exp_id = 2'((k - 2) % 4);
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_valid k=%0d got=%b want=1", k, rsp_valid); end
            checks++; if (rsp_id !== exp_id) begin errors++; $display("FAIL rr_id k=%0d got=%0d want=%0d", k, rsp_id, exp_id); end
            checks++; if (rsp_sum !== rr_sum[exp_id]) begin errors++; $display("FAIL rr_sum k=%0d got=%h want=%h", k, rsp_sum, rr_sum[exp_id]); end
         end
         tick;
      end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_drain got=%b want=0", rsp_valid); end
   endtask

   task automatic test_backpressure;
      do_reset;
      load_rr_operands;
      rsp_ready = 1'b0;
      req_valid = 4'b1111;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_grant0 got=%b want=0001", req_ready); end
      tick;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant1 got=%b want=0010", req_ready); end
      tick;
      for (int k = 0; k < 3; k++) begin
         checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready k=%0d got=%b want=0000", k, req_ready); end
         checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid k=%0d got=%b want=1", k, rsp_valid); end
         checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL bp_id k=%0d got=%0d want=0", k, rsp_id); end
         checks++; if (rsp_sum !== 17'h00010) begin errors++; $display("FAIL bp_sum k=%0d got=%h want=00010", k, rsp_sum); end
         tick;
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin errors++; $display("FAIL bp_first got=%b/%0d want=1/0", rsp_valid, rsp_id); end
      tick;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin errors++; $display("FAIL bp_second got=%b/%0d want=1/1", rsp_valid, rsp_id); end
      checks++; if (rsp_sum !== 17'h00111) begin errors++; $display("FAIL bp_second_sum got=%h want=00111", rsp_sum); end
      tick;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_nodup got=%b want=0", rsp_valid); end
   endtask

   task automatic test_reset_mid;
      do_reset;
      load_rr_operands;
      rsp_ready = 1'b0;
      req_valid = 4'b1111;
      tick;
      tick;
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_inflight got=%b want=1", rsp_valid); end
      reset_n   = 1'b0;
      req_valid = '0;
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b want=0", rsp_valid); end
      tick;
      tick;
      reset_n   = 1'b1;
      rsp_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_stale k=%0d got=%b want=0", k, rsp_valid); end
         tick;
      end
      req_valid = 4'b1111;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_mid_grant got=%b want=0001", req_ready); end
      tick;
      req_valid = '0;
      tick;
      tick;
   endtask

   task automatic test_single_stream;
      do_reset;
      req_a[47:32] = 16'h0005;
      req_b[47:32] = 16'h0006;
      req_valid    = 4'b0100;
      for (int k = 0; k < 6; k++) begin
         if (k == 4) req_valid = '0;
         #1;
         if (k < 4) begin
            checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant k=%0d got=%b want=0100", k, req_ready); end
         end
         if (k >= 2) begin
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 17'h0000B) begin errors++; $display("FAIL single_rsp k=%0d got=%b/%0d/%h want=1/2/0000b", k, rsp_valid, rsp_id, rsp_sum); end
         end
         tick;
      end
   endtask

`ifdef ADDSHARE_LOCK_EN
   task automatic test_lock;
      do_reset;
      load_rr_operands;
      req_valid = 4'b0001;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL lock_pre got=%b want=0001", req_ready); end
      tick;
      req_valid = 4'b1111;
      req_lock  = 4'b0010;
      #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL lock_g1 got=%b want=0010", req_ready); end
      tick;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL lock_g2 got=%b want=0010", req_ready); end
      tick;
      req_lock = 4'b0000;
      #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL lock_g3 got=%b want=0010", req_ready); end
      tick;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL lock_release got=%b want=0100", req_ready); end
      req_valid = '0;
      tick;
      tick;
   endtask
`endif

   initial begin
      test_reset;
      test_basic;
      test_carry;
      test_round_robin;
      test_backpressure;
      test_reset_mid;
      test_single_stream;
`ifdef ADDSHARE_LOCK_EN
      test_lock;
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
